// File: rtl/tfc_delay_ctrl.sv
// tfc_delay_ctrl: validates delay-length requests, applies them to fifo_len on an
// orbit sync strobe and blanks the delayed TFC output until the tap change settles.
module tfc_delay_ctrl #(
  parameter int MAX_LEN = 254,
  parameter int RESET_LEN = 0,
  parameter int SYNC_TIMEOUT = 3564
) (
  input  logic       main_clk,
  input  logic       rst_n,
  input  logic [7:0] cfg_len,
  input  logic       cfg_req,
  output logic       cfg_ack,
  output logic       cfg_err,
  input  logic       sync_in,
  output logic [7:0] fifo_len,
  output logic       out_blank,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, WAIT_SYNC, SETTLE} state_t;
  localparam logic [11:0] T_LAST = 12'(SYNC_TIMEOUT - 1);
  state_t state, state_nxt;
  logic [7:0] fifo_len_nxt, pending_len, pending_nxt, settle_cnt, settle_nxt;
  logic [11:0] tcnt, tcnt_nxt;
  logic armed, armed_nxt, ack_nxt, err_nxt, blank_nxt, accept, over;
  assign accept = cfg_req && armed && state == IDLE;
  assign over = 32'(cfg_len) > MAX_LEN;
  always_comb begin
    state_nxt = state;
    fifo_len_nxt = fifo_len;
    pending_nxt = pending_len;
    settle_nxt = settle_cnt;
    tcnt_nxt = tcnt;
    ack_nxt = 1'b0;
    err_nxt = 1'b0;
    blank_nxt = out_blank;
    case (state)
      IDLE: if (accept) begin
        if (over || cfg_len == fifo_len) begin
          ack_nxt = 1'b1;
          err_nxt = over;
        end else begin
          pending_nxt = cfg_len;
          tcnt_nxt = 12'd0;
          state_nxt = WAIT_SYNC;
        end
      end
      WAIT_SYNC: if (sync_in) begin
        fifo_len_nxt = pending_len;
        // settling must cover the longer of the two tap paths
        settle_nxt = fifo_len > pending_len ? fifo_len : pending_len;
        blank_nxt = 1'b1;
        state_nxt = SETTLE;
      end else if (tcnt == T_LAST) begin
        ack_nxt = 1'b1;
        err_nxt = 1'b1;
        state_nxt = IDLE;
      end else begin
        tcnt_nxt = tcnt == 12'hfff ? tcnt : tcnt + 12'd1;
      end
      SETTLE: if (settle_cnt == 8'd0) begin
        blank_nxt = 1'b0;
        ack_nxt = 1'b1;
        state_nxt = IDLE;
      end else begin
        settle_nxt = settle_cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
    // disarm at the ack edge so a still-held request cannot retrigger
    armed_nxt = ack_nxt ? 1'b0 : !cfg_req ? 1'b1 : armed;
  end
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fifo_len <= 8'(RESET_LEN);
      pending_len <= 8'd0;
      settle_cnt <= 8'd0;
      tcnt <= 12'd0;
      armed <= 1'b1;
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      out_blank <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nxt;
      fifo_len <= fifo_len_nxt;
      pending_len <= pending_nxt;
      settle_cnt <= settle_nxt;
      tcnt <= tcnt_nxt;
      armed <= armed_nxt;
      cfg_ack <= ack_nxt;
      cfg_err <= err_nxt;
      out_blank <= blank_nxt;
      busy <= state_nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_tfc_delay_ctrl.sv
// tb_tfc_delay_ctrl: directed checks of request validation, sync-aligned apply,
// settle blanking, timeout, held-request suppression and mid-operation reset.
module tb_tfc_delay_ctrl;
  logic main_clk = 1'b0, rst_n = 1'b0;
  logic [7:0] cfg_len = 8'd0, fifo_len;
  logic cfg_req = 1'b0, sync_in = 1'b0, cfg_ack, cfg_err, out_blank, busy;
  int passed = 0, total = 0;
  tfc_delay_ctrl #(.MAX_LEN(254), .RESET_LEN(0), .SYNC_TIMEOUT(16)) dut (
    .main_clk(main_clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_req(cfg_req),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .sync_in(sync_in), .fifo_len(fifo_len),
    .out_blank(out_blank), .busy(busy)
  );
  always #5 main_clk = ~main_clk;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask
  task automatic request(input logic [7:0] len);
    cfg_len = len;
    cfg_req = 1'b1;
    @(negedge main_clk);
  endtask
  task automatic release_req();
    cfg_req = 1'b0;
    @(negedge main_clk);
  endtask
  task automatic settle(input int exp_len, input int exp_blank, input bit noisy);
    int n = 0, early = 0;
    sync_in = 1'b1;
    @(negedge main_clk);
    sync_in = 1'b0;
    check("fifo_after_sync", fifo_len, exp_len);
    check("blank_after_sync", out_blank, 1);
    while (out_blank && n < 400) begin
      n++;
      early += cfg_ack;
      if (noisy) begin
        sync_in = n[0];
        cfg_len = 8'($urandom);
      end
      @(negedge main_clk);
    end
    sync_in = 1'b0;
    check("blank_len", n, exp_blank);
    check("early_ack", early, 0);
    check("settle_ack", cfg_ack, 1);
    check("settle_err", cfg_err, 0);
    check("settle_busy", busy, 0);
    check("settle_fifo", fifo_len, exp_len);
  endtask
  initial begin
    int k, acks, blanks;
    repeat (2) @(negedge main_clk);
    check("rst_fifo", fifo_len, 0);
    check("rst_ack", cfg_ack, 0);
    check("rst_err", cfg_err, 0);
    check("rst_blank", out_blank, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge main_clk);
    request(8'd10);
    check("acc_busy", busy, 1);
    check("acc_fifo", fifo_len, 0);
    repeat (4) @(negedge main_clk);
    settle(10, 11, 1'b0);
    release_req();
    request(8'd255);
    check("rej_ack", cfg_ack, 1);
    check("rej_err", cfg_err, 1);
    check("rej_fifo", fifo_len, 10);
    check("rej_blank", out_blank, 0);
    check("rej_busy", busy, 0);
    release_req();
    request(8'd10);
    check("noop_ack", cfg_ack, 1);
    check("noop_err", cfg_err, 0);
    check("noop_blank", out_blank, 0);
    acks = 0;
    repeat (20) begin
      @(negedge main_clk);
      acks += cfg_ack;
    end
    check("held_no_reack", acks, 0);
    release_req();
    request(8'd50);
    k = 0;
    blanks = 0;
    while (!cfg_ack && k < 100) begin
      k++;
      blanks += out_blank;
      @(negedge main_clk);
    end
    check("tmo_cycles", k, 16);
    check("tmo_err", cfg_err, 1);
    check("tmo_fifo", fifo_len, 10);
    check("tmo_blank", blanks, 0);
    check("tmo_busy", busy, 0);
    release_req();
    request(8'd200);
    settle(200, 201, 1'b0);
    release_req();
    request(8'd3);
    settle(3, 201, 1'b1);
    release_req();
    request(8'd20);
    sync_in = 1'b1;
    @(negedge main_clk);
    sync_in = 1'b0;
    repeat (5) @(negedge main_clk);
    check("pre_rst_blank", out_blank, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_fifo", fifo_len, 0);
    check("mid_rst_blank", out_blank, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ack", cfg_ack, 0);
    @(negedge main_clk);
    rst_n = 1'b1;
    release_req();
    request(8'd7);
    check("post_rst_busy", busy, 1);
    settle(7, 8, 1'b0);
    release_req();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
